kick_scheduler: RTL and testbench

Sequencing controller for the shoot/chip pulse generator on the core board. Latches kick commands from the radio-command decoder, which can request an immediate kick or an armed auto-kick that fires on the infrared ball-detect. It gates firing on booster-capacitor readiness, then drives the pulse generator's enable and strength. It holds strength stable for the whole discharge, inhibits the charger during discharge, and enforces a cooldown before the next kick.

---
 rtl/kick_scheduler_if.sv | 26 ++
 rtl/kick_scheduler.sv | 160 ++++++++++++++++
 tb/tb_kick_scheduler.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/kick_scheduler_if.sv
// rtl/kick_scheduler_if.sv - command, ball-detect and pulse-generator signals of the kick scheduler
interface kick_scheduler_if;
  logic       cmd_valid;
  logic [7:0] cmd_strength;
  logic       cmd_auto;
  logic       cmd_cancel;
  logic       ball_det;
  logic       cap_ready;
  logic       kick_en;
  logic [7:0] kick_strength;
  logic       charge_inhibit;
  logic       armed;
  logic       busy;
  logic       done;
  logic       reject;

  modport master (
    output cmd_valid, cmd_strength, cmd_auto, cmd_cancel, ball_det, cap_ready,
    input  kick_en, kick_strength, charge_inhibit, armed, busy, done, reject
  );

  modport slave (
    input  cmd_valid, cmd_strength, cmd_auto, cmd_cancel, ball_det, cap_ready,
    output kick_en, kick_strength, charge_inhibit, armed, busy, done, reject
  );
endinterface

// File: rtl/kick_scheduler.sv
// rtl/kick_scheduler.sv - kick sequencer: arm/fire on ball detect, capacitor gating, pulse timing, cooldown
module kick_scheduler #(
  parameter int UNIT_CYC        = 2502,
  parameter int EN_HOLD         = 4,
  parameter int GUARD_CYC       = 2502,
  parameter int COOLDOWN_CYC    = 12_500_000,
  parameter int DEBOUNCE_CYC    = 16,
  parameter int ARM_TIMEOUT_CYC = 250_000_000
) (
  input  logic             clk0,
  input  logic             rst,
  kick_scheduler_if.slave  kif
);

  localparam int          DW        = $clog2(DEBOUNCE_CYC + 2);
  localparam logic [31:0] UNIT_W    = 32'(UNIT_CYC);
  localparam logic [31:0] GUARD_W   = 32'(GUARD_CYC);
  localparam logic [31:0] FIRE_LOAD = 32'(EN_HOLD - 1);
  localparam logic [31:0] COOL_LOAD = 32'(COOLDOWN_CYC - 1);
  localparam logic [31:0] ARM_LOAD  = 32'(ARM_TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_FIRE, S_PULSE, S_COOL} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pulse_len_q, pulse_len_d;
  logic [7:0]  strength_q, strength_d;
  logic        kick_en_q, kick_en_d;
  logic        inhibit_q, inhibit_d;
  logic        armed_q, armed_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        reject_q, reject_d;

  logic [1:0]    sync_q;
  logic [DW-1:0] deb_q;
  logic          ball_ok;

  // Debounce counts consecutive synchronized-high samples and saturates at the threshold
  assign ball_ok = (deb_q == DEBOUNCE_CYC[DW-1:0]);

  always_ff @(posedge clk0) begin
    if (rst) begin
      sync_q <= '0;
      deb_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], kif.ball_det};
      if (!sync_q[1]) begin
        deb_q <= '0;
      end else if (!ball_ok) begin
        deb_q <= deb_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pulse_len_q <= '0;
      strength_q  <= '0;
      kick_en_q   <= 1'b0;
      inhibit_q   <= 1'b0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse_len_q <= pulse_len_d;
      strength_q  <= strength_d;
      kick_en_q   <= kick_en_d;
      inhibit_q   <= inhibit_d;
      armed_q     <= armed_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      reject_q    <= reject_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    strength_d = strength_q;
    reject_d   = 1'b0;
    cnt_d      = (cnt_q != 32'd0) ? cnt_q - 32'd1 : cnt_q;
    case (state_q)
      S_IDLE, S_ARMED: begin
        // A command in ARMED outranks cancel, ball detect and timeout in the same cycle
        if (kif.cmd_valid) begin
          if (kif.cmd_strength[6:0] == 7'd0) begin
            reject_d = 1'b1;
          end else if (kif.cmd_auto) begin
            state_d    = S_ARMED;
            strength_d = kif.cmd_strength;
            cnt_d      = ARM_LOAD;
          end else if (kif.cap_ready) begin
            state_d    = S_FIRE;
            strength_d = kif.cmd_strength;
            cnt_d      = FIRE_LOAD;
          end else begin
            reject_d = 1'b1;
          end
        end else if (state_q == S_ARMED) begin
          if (kif.cmd_cancel) begin
            state_d = S_IDLE;
          end else if (ball_ok && kif.cap_ready) begin
            state_d = S_FIRE;
            cnt_d   = FIRE_LOAD;
          end else if ((ARM_TIMEOUT_CYC != 0) && (cnt_q == 32'd0)) begin
            state_d = S_IDLE;
          end
        end
      end
      S_FIRE: begin
        reject_d = kif.cmd_valid;
        if (cnt_q == 32'd0) begin
          state_d = S_PULSE;
          cnt_d   = pulse_len_q - 32'd1;
        end
      end
      S_PULSE: begin
        reject_d = kif.cmd_valid;
        if (cnt_q == 32'd0) begin
          state_d = S_COOL;
          cnt_d   = COOL_LOAD;
        end
      end
      S_COOL: begin
        reject_d = kif.cmd_valid;
        if (cnt_q == 32'd0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register
  always_comb begin
    kick_en_d   = (state_d == S_FIRE);
    inhibit_d   = (state_d == S_FIRE) || (state_d == S_PULSE);
    armed_d     = (state_d == S_ARMED);
    busy_d      = (state_d == S_FIRE) || (state_d == S_PULSE) || (state_d == S_COOL);
    done_d      = (state_d == S_COOL) && (state_q != S_COOL);
    pulse_len_d = pulse_len_q;
    if ((state_d == S_FIRE) && (state_q != S_FIRE)) begin
      pulse_len_d = {25'd0, strength_d[6:0]} * UNIT_W + GUARD_W;
    end
  end

  assign kif.kick_en        = kick_en_q;
  assign kif.kick_strength  = strength_q;
  assign kif.charge_inhibit = inhibit_q;
  assign kif.armed          = armed_q;
  assign kif.busy           = busy_q;
  assign kif.done           = done_q;
  assign kif.reject         = reject_q;

endmodule

// File: tb/tb_kick_scheduler.sv
// tb/tb_kick_scheduler.sv - directed vector table plus hand sequences for kick_scheduler
module tb_kick_scheduler;
  logic clk0 = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk0 = ~clk0;

  kick_scheduler_if kif();

  kick_scheduler #(
    .UNIT_CYC(10), .EN_HOLD(4), .GUARD_CYC(5), .COOLDOWN_CYC(50),
    .DEBOUNCE_CYC(4), .ARM_TIMEOUT_CYC(200)
  ) dut (
    .clk0(clk0),
    .rst (rst),
    .kif (kif)
  );

  typedef struct packed {
    logic       v;
    logic [7:0] s;
    logic       au;
    logic       ca;
    logic       cr;
    int         idle;
    logic       en;
    logic       ci;
    logic       ar;
    logic       bu;
    logic       dn;
    logic       rj;
    logic [7:0] ks;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  function automatic vec_t mk(logic v, logic [7:0] s, logic au, logic ca, logic cr, int idle,
                              logic en, logic ci, logic ar, logic bu, logic dn, logic rj,
                              logic [7:0] ks);
    vec_t r;
    r.v = v; r.s = s; r.au = au; r.ca = ca; r.cr = cr; r.idle = idle;
    r.en = en; r.ci = ci; r.ar = ar; r.bu = bu; r.dn = dn; r.rj = rj; r.ks = ks;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic en, input logic ci, input logic ar,
                         input logic bu, input logic dn, input logic rj, input logic [7:0] ks);
    chk({tag, "_kick_en"},        32'(kif.kick_en),        32'(en));
    chk({tag, "_charge_inhibit"}, 32'(kif.charge_inhibit), 32'(ci));
    chk({tag, "_armed"},          32'(kif.armed),          32'(ar));
    chk({tag, "_busy"},           32'(kif.busy),           32'(bu));
    chk({tag, "_done"},           32'(kif.done),           32'(dn));
    chk({tag, "_reject"},         32'(kif.reject),         32'(rj));
    chk({tag, "_kick_strength"},  32'(kif.kick_strength),  32'(ks));
  endtask

  task automatic send(input logic [7:0] s, input logic au);
    kif.cmd_valid    = 1'b1;
    kif.cmd_strength = s;
    kif.cmd_auto     = au;
    tick();
    kif.cmd_valid    = 1'b0;
  endtask

  task automatic wait_not_busy(input string nm, input int bound);
    for (int k = 0; k < bound && kif.busy; k++) tick();
    chk(nm, 32'(kif.busy), 32'd0);
  endtask

  always @(negedge clk0) begin
    if (!rst) begin
      checks++;
      if (kif.armed && kif.busy) begin
        errors++;
        $display("FAIL armed_busy_overlap: got armed=1 busy=1 expected not both");
      end
    end
  end

  initial begin
    int rise;
    int n;

    tbl[0]  = mk(1, 8'h80, 0, 0, 1,   0,  0, 0, 0, 0, 0, 1, 8'h00);
    tbl[1]  = mk(1, 8'h03, 0, 0, 0,   0,  0, 0, 0, 0, 0, 1, 8'h00);
    tbl[2]  = mk(1, 8'h03, 0, 0, 1,   0,  1, 1, 0, 1, 0, 0, 8'h03);
    tbl[3]  = mk(0, 8'h00, 0, 0, 1,   2,  1, 1, 0, 1, 0, 0, 8'h03);
    tbl[4]  = mk(0, 8'h00, 0, 0, 1,   0,  0, 1, 0, 1, 0, 0, 8'h03);
    tbl[5]  = mk(1, 8'h07, 0, 0, 1,   0,  0, 1, 0, 1, 0, 1, 8'h03);
    tbl[6]  = mk(0, 8'h00, 0, 0, 1,  32,  0, 1, 0, 1, 0, 0, 8'h03);
    tbl[7]  = mk(0, 8'h00, 0, 0, 1,   0,  0, 0, 0, 1, 1, 0, 8'h03);
    tbl[8]  = mk(0, 8'h00, 0, 0, 1,   0,  0, 0, 0, 1, 0, 0, 8'h03);
    tbl[9]  = mk(0, 8'h00, 0, 0, 1,  47,  0, 0, 0, 1, 0, 0, 8'h03);
    tbl[10] = mk(0, 8'h00, 0, 0, 1,   0,  0, 0, 0, 0, 0, 0, 8'h03);
    tbl[11] = mk(1, 8'h85, 1, 0, 1,   0,  0, 0, 1, 0, 0, 0, 8'h85);
    tbl[12] = mk(1, 8'h86, 1, 0, 1,   0,  0, 0, 1, 0, 0, 0, 8'h86);
    tbl[13] = mk(1, 8'h87, 1, 1, 1,   0,  0, 0, 1, 0, 0, 0, 8'h87);
    tbl[14] = mk(0, 8'h00, 0, 1, 1,   0,  0, 0, 0, 0, 0, 0, 8'h87);
    tbl[15] = mk(1, 8'h02, 1, 0, 1,   0,  0, 0, 1, 0, 0, 0, 8'h02);
    tbl[16] = mk(0, 8'h00, 0, 0, 1, 198,  0, 0, 1, 0, 0, 0, 8'h02);
    tbl[17] = mk(0, 8'h00, 0, 0, 1,   0,  0, 0, 0, 0, 0, 0, 8'h02);

    kif.cmd_valid    = 1'b0;
    kif.cmd_strength = 8'h00;
    kif.cmd_auto     = 1'b0;
    kif.cmd_cancel   = 1'b0;
    kif.ball_det     = 1'b0;
    kif.cap_ready    = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 8'h00);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      kif.cmd_valid    = tbl[i].v;
      kif.cmd_strength = tbl[i].s;
      kif.cmd_auto     = tbl[i].au;
      kif.cmd_cancel   = tbl[i].ca;
      kif.cap_ready    = tbl[i].cr;
      tick();
      kif.cmd_valid  = 1'b0;
      kif.cmd_cancel = 1'b0;
      repeat (tbl[i].idle) tick();
      chk_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].ci, tbl[i].ar, tbl[i].bu,
              tbl[i].dn, tbl[i].rj, tbl[i].ks);
    end

    // Auto chip: a 3-cycle glitch must not fire, a held detect fires 2+4+1 cycles later
    kif.cap_ready = 1'b1;
    send(8'h85, 1'b1);
    chk("auto_armed", 32'(kif.armed), 32'd1);
    kif.ball_det = 1'b1;
    repeat (3) tick();
    kif.ball_det = 1'b0;
    repeat (8) tick();
    chk("glitch_armed", 32'(kif.armed), 32'd1);
    chk("glitch_no_fire", 32'(kif.kick_en), 32'd0);
    kif.ball_det = 1'b1;
    rise = -1;
    for (int k = 1; k <= 20 && rise < 0; k++) begin
      tick();
      if (kif.kick_en) rise = k;
    end
    chk("auto_fire_latency", 32'(rise), 32'd7);
    chk("auto_strength", 32'(kif.kick_strength), 32'h85);
    kif.ball_det = 1'b0;
    wait_not_busy("auto_complete", 300);

    // Capacitor gating while armed with the ball present
    send(8'h04, 1'b1);
    kif.cap_ready = 1'b0;
    kif.ball_det  = 1'b1;
    repeat (12) tick();
    chk("capwait_armed", 32'(kif.armed), 32'd1);
    chk("capwait_no_fire", 32'(kif.kick_en), 32'd0);
    kif.cap_ready = 1'b1;
    tick();
    chk("cap_fire", 32'(kif.kick_en), 32'd1);
    chk("cap_fire_armed", 32'(kif.armed), 32'd0);
    chk("cap_fire_strength", 32'(kif.kick_strength), 32'h04);
    kif.ball_det = 1'b0;
    wait_not_busy("cap_complete", 300);

    // Reset in the middle of PULSE, then a normal immediate kick
    send(8'h02, 1'b0);
    repeat (6) tick();
    chk("pre_rst_inhibit", 32'(kif.charge_inhibit), 32'd1);
    chk("pre_rst_en", 32'(kif.kick_en), 32'd0);
    rst = 1'b1;
    tick();
    chk_all("mid_rst", 0, 0, 0, 0, 0, 0, 8'h00);
    rst = 1'b0;
    send(8'h01, 1'b0);
    chk("post_rst_fire", 32'(kif.kick_en), 32'd1);
    chk("post_rst_strength", 32'(kif.kick_strength), 32'h01);
    n = 1;
    for (int k = 0; k < 10 && kif.kick_en; k++) begin
      tick();
      if (kif.kick_en) n++;
    end
    chk("post_rst_en_len", 32'(n), 32'd4);
    wait_not_busy("post_rst_complete", 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
